// File: rtl/svpwm_pkg.sv
// Shared SVPWM definitions: FSM encoding and default timing constants.
// The CCR calculator uses the same constants, so its T/2 matches the PWM counter peak.
package svpwm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown
  } state_e;

  localparam int unsigned DefCntW       = 12;
  localparam int unsigned DefHalfPeriod = 2499;
  localparam int unsigned DefDeadCyc    = 50;
  localparam int unsigned DefDtW        = 8;

endpackage

// File: rtl/svpwm_pwm_gen_if.sv
// Compare-set handshake between the CCR calculator (master) and the PWM generator (slave).
interface svpwm_pwm_gen_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = svpwm_pkg::DefCntW
);

  logic                    iCCR_valid;
  logic [NUM_CH*CNT_W-1:0] iCCR;
  logic                    oCCR_ready;

  modport master (
    output iCCR_valid,
    output iCCR,
    input  oCCR_ready
  );

  modport slave (
    input  iCCR_valid,
    input  iCCR,
    output oCCR_ready
  );

endinterface

// File: rtl/svpwm_deadtime.sv
// Per-channel dead-time inserter: complementary gate pair, both held off for
// DEAD_CYC cycles after every change of the raw level.
module svpwm_deadtime import svpwm_pkg::*; #(
  parameter int unsigned DEAD_CYC = DefDeadCyc,
  parameter int unsigned DT_W     = DefDtW
) (
  input  logic iClk,
  input  logic iRst,
  input  logic raw,
  input  logic force_off,
  output logic h,
  output logic l
);

  logic            level_q, level_d;
  logic [DT_W-1:0] dtcnt_q, dtcnt_d;

  // A new edge during dead-time reloads the counter, swallowing short glitches.
  always_comb begin
    level_d = level_q;
    dtcnt_d = dtcnt_q;
    if (raw != level_q) begin
      level_d = raw;
      dtcnt_d = DT_W'(DEAD_CYC);
    end else if (dtcnt_q != '0) begin
      dtcnt_d = dtcnt_q - DT_W'(1);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      level_q <= 1'b0;
      dtcnt_q <= '0;
    end else begin
      level_q <= level_d;
      dtcnt_q <= dtcnt_d;
    end
  end

  assign h = ~force_off & (dtcnt_q == '0) & level_q;
  assign l = ~force_off & (dtcnt_q == '0) & ~level_q;

endmodule

// File: rtl/svpwm_pwm_gen.sv
// Centre-aligned PWM generator: up/down counter, shadow-buffered compares loaded at
// the valley, and one dead-time inserter per half-bridge.
module svpwm_pwm_gen import svpwm_pkg::*; #(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned HALF_PERIOD = DefHalfPeriod,
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DEAD_CYC    = DefDeadCyc,
  parameter int unsigned DT_W        = DefDtW
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  svpwm_pwm_gen_if.slave    ccr,
  output logic [NUM_CH-1:0] oPWM_h,
  output logic [NUM_CH-1:0] oPWM_l,
  output logic              oPeriod_done,
  output logic              oActive,
  output logic [CNT_W-1:0]  oCnt
);

  localparam logic [CNT_W-1:0] Peak = CNT_W'(HALF_PERIOD);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  active_q, active_d;
  logic                          pending_q, pending_d;
  logic                          load;
  logic                          xfer;
  logic                          running;
  logic                          valley;
  logic [NUM_CH-1:0]             raw;

  assign running = (state_q != StIdle);
  assign valley  = (state_q == StDown) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (iEn) begin
          state_d = StUp;
          cnt_d   = CNT_W'(1);
          load    = 1'b1;
        end
      end
      StUp: begin
        if (cnt_q == Peak) begin
          state_d = StDown;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDown: begin
        if (cnt_q == '0) begin
          load = pending_q;
          // Stop requests only take effect here, so the last period is never truncated.
          if (iEn) begin
            state_d = StUp;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign ccr.oCCR_ready = ~iRst;
  assign xfer           = ccr.iCCR_valid & ccr.oCCR_ready;

  // A write coinciding with a load lands in the shadow and waits for the next valley.
  always_comb begin
    shadow_d  = xfer ? ccr.iCCR : shadow_q;
    active_d  = load ? shadow_q : active_q;
    pending_d = xfer | (pending_q & ~load);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign raw[i] = running & (cnt_q >= active_q[i]);

    svpwm_deadtime #(
      .DEAD_CYC (DEAD_CYC),
      .DT_W     (DT_W)
    ) u_dt (
      .iClk      (iClk),
      .iRst      (iRst),
      .raw       (raw[i]),
      .force_off (~running),
      .h         (oPWM_h[i]),
      .l         (oPWM_l[i])
    );
  end

  assign oPeriod_done = valley;
  assign oActive      = running;
  assign oCnt         = cnt_q;

endmodule

// File: tb/tb_svpwm_pwm_gen.sv
// Bench for svpwm_pwm_gen: per-period gate widths checked against a scoreboard of
// expectations derived from the written compare values.
module tb_svpwm_pwm_gen;

  localparam int unsigned CW  = 12;
  localparam int unsigned H   = 2499;
  localparam int unsigned NCH = 3;
  localparam int unsigned D   = 50;
  localparam int unsigned DTW = 8;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iEn;
  logic [NCH-1:0]    pwm_h;
  logic [NCH-1:0]    pwm_l;
  logic              period_done;
  logic              active;
  logic [CW-1:0]     cnt;

  always #5 iClk = ~iClk;

  svpwm_pwm_gen_if #(.NUM_CH(NCH), .CNT_W(CW)) ccr_if ();

  svpwm_pwm_gen #(
    .CNT_W       (CW),
    .HALF_PERIOD (H),
    .NUM_CH      (NCH),
    .DEAD_CYC    (D),
    .DT_W        (DTW)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iEn          (iEn),
    .ccr          (ccr_if),
    .oPWM_h       (pwm_h),
    .oPWM_l       (pwm_l),
    .oPeriod_done (period_done),
    .oActive      (active),
    .oCnt         (cnt)
  );

  typedef struct packed {
    logic [NCH-1:0]       h_chk;
    logic [NCH-1:0]       l_chk;
    logic [NCH-1:0][31:0] h;
    logic [NCH-1:0][31:0] l;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state (only the monitor writes these)
  int unsigned m_shadow[NCH];
  int unsigned m_active[NCH];
  int unsigned m_prev[NCH];
  bit          m_pending;
  bit          m_running;
  int unsigned h_cnt[NCH];
  int unsigned l_cnt[NCH];
  int unsigned win_len;
  int unsigned overlap = 0;
  bit          start;
  exp_t        e_pop;

  // Expected gate widths over one window (cnt=1 .. valley) for the current active set.
  function automatic exp_t make_exp(input bit first);
    exp_t e;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      int unsigned c  = m_active[i];
      int unsigned pc = m_prev[i];
      int unsigned r;
      e.h_chk[i] = 1'b1;
      if (c == 0) begin
        if (first) e.h[i] = 2*H - 1 - D;
        else if (pc == 0) begin
          e.h[i] = 2*H;
          e.l_chk[i] = 1'b1;
          e.l[i] = 0;
        end else e.h_chk[i] = 1'b0;
      end else if (c > H) begin
        e.h[i] = 0;
        if (first || pc > H) begin
          e.l_chk[i] = 1'b1;
          e.l[i] = 2*H;
        end
      end else begin
        if (!first && pc == 0) e.h_chk[i] = 1'b0;
        r = 2*H - 2*c + 1;
        e.h[i] = (r > D) ? r - D : 0;
        if ((first || pc == c) && (c - 1 > D)) begin
          e.l_chk[i] = 1'b1;
          e.l[i] = c + (c - 1 - D);
        end
      end
    end
    return e;
  endfunction

  always @(negedge iClk) begin
    if (iRst) begin
      sb.delete();
      m_pending = 1'b0;
      m_running = 1'b0;
      win_len   = 0;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_prev[i] = 0; h_cnt[i] = 0; l_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (pwm_h[i] && pwm_l[i]) overlap++;
        h_cnt[i] += int'(pwm_h[i]);
        l_cnt[i] += int'(pwm_l[i]);
      end
      win_len++;
      if (period_done) begin
        check("period_len", win_len, 2*H);
        check("valley_cnt", cnt, 0);
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e_pop = sb.pop_front();
          for (int i = 0; i < NCH; i++) begin
            if (e_pop.h_chk[i]) check($sformatf("h_width_ch%0d", i), h_cnt[i], e_pop.h[i]);
            if (e_pop.l_chk[i]) check($sformatf("l_width_ch%0d", i), l_cnt[i], e_pop.l[i]);
          end
        end
      end
      start = !m_running && iEn;
      if (start || period_done) begin
        for (int i = 0; i < NCH; i++) m_prev[i] = m_active[i];
        if (start || m_pending) begin
          for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
          m_pending = 1'b0;
        end
        if (iEn) begin
          sb.push_back(make_exp(start));
          m_running = 1'b1;
        end else m_running = 1'b0;
        win_len = 0;
        for (int i = 0; i < NCH; i++) begin
          h_cnt[i] = 0; l_cnt[i] = 0;
        end
      end
      if (ccr_if.iCCR_valid) begin
        for (int i = 0; i < NCH; i++) m_shadow[i] = int'(ccr_if.iCCR[i*CW +: CW]);
        m_pending = 1'b1;
      end
    end
  end

  function automatic logic [NCH*CW-1:0] pack3(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    return {CW'(c), CW'(b), CW'(a)};
  endfunction

  task automatic write_ccr(input logic [NCH*CW-1:0] v, input bit at_valley);
    @(posedge iClk); #1;
    ccr_if.iCCR_valid = 1'b1;
    ccr_if.iCCR       = v;
    @(negedge iClk);
    if (at_valley) check("valley_write_aligned", period_done, 1);
    @(posedge iClk); #1;
    ccr_if.iCCR_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int unsigned target, input bit down, input string tag);
    int unsigned prev;
    bit hit = 1'b0;
    @(negedge iClk);
    prev = cnt;
    for (int k = 0; k < 6000 && !hit; k++) begin
      @(negedge iClk);
      if (cnt == target && ((cnt < prev) == down)) hit = 1'b1;
      else prev = cnt;
    end
    if (!hit) check({"timeout_", tag}, 0, 1);
  endtask

  task automatic wait_valleys(input int unsigned n, input string tag);
    int unsigned seen = 0;
    for (int k = 0; k < n*(2*H + 20) && seen < n; k++) begin
      @(negedge iClk);
      if (period_done) seen++;
    end
    check({"valleys_", tag}, seen, n);
  endtask

  initial begin
    iRst = 1'b1;
    iEn  = 1'b0;
    ccr_if.iCCR_valid = 1'b0;
    ccr_if.iCCR       = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check("rst_ready", ccr_if.oCCR_ready, 0);
    check("rst_cnt", cnt, 0);
    check("rst_active", active, 0);
    @(posedge iClk); #1 iRst = 1'b0;
    @(negedge iClk);
    check("ready_after_rst", ccr_if.oCCR_ready, 1);
    check("idle_gates", {pwm_h, pwm_l}, 0);

    // Steady 1000 on all channels
    write_ccr(pack3(1000, 1000, 1000), 1'b0);
    @(posedge iClk); #1 iEn = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("start_cnt", cnt, 1);
    check("start_active", active, 1);
    wait_valleys(2, "steady");

    // Mid-period shadow write must not disturb the running period
    wait_cnt(500, 1'b0, "w3_500");
    write_ccr(pack3(2000, 2480, 3000), 1'b0);
    wait_valleys(1, "w3");

    // Write mid-period, then overwrite on the valley cycle itself
    wait_cnt(500, 1'b0, "w4_500");
    write_ccr(pack3(1500, 200, 2499), 1'b0);
    wait_cnt(1, 1'b1, "w4_last");
    write_ccr(pack3(300, 300, 300), 1'b1);
    wait_valleys(1, "w5");

    // Stop mid-DOWN: period completes, then idle
    wait_cnt(1500, 1'b1, "w6_1500");
    @(posedge iClk); #1 iEn = 1'b0;
    wait_valleys(1, "stop");
    @(negedge iClk);
    check("stop_active", active, 0);
    check("stop_cnt", cnt, 0);
    check("stop_gates", {pwm_h, pwm_l}, 0);
    repeat (20) @(negedge iClk);
    check("idle_stays_cnt", cnt, 0);
    check("idle_stays_active", active, 0);

    // Restart with 0 / mid / beyond-peak compares
    write_ccr(pack3(0, 1000, 3000), 1'b0);
    @(posedge iClk); #1 iEn = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("restart_cnt", cnt, 1);
    wait_valleys(2, "restart");

    // Reset mid-UP
    wait_cnt(1200, 1'b0, "w9_1200");
    @(posedge iClk); #1;
    iRst = 1'b1;
    iEn  = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    check("midrst_cnt", cnt, 0);
    check("midrst_active", active, 0);
    check("midrst_gates", {pwm_h, pwm_l}, 0);
    check("midrst_done", period_done, 0);
    check("midrst_ready", ccr_if.oCCR_ready, 0);
    @(posedge iClk); #1 iRst = 1'b0;
    repeat (10) @(negedge iClk);
    check("post_rst_cnt", cnt, 0);
    check("post_rst_active", active, 0);
    check("post_rst_ready", ccr_if.oCCR_ready, 1);

    check("no_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
